seq_alu: RTL and testbench

Registered, parametrised successor to the board-level 4-bit ALU. It accepts two WIDTH-bit operands and an opcode under a start/done handshake and holds a 2·WIDTH-bit result register. It adds an accumulate operation, a multi-cycle shift-add multiply, and status flags. It sits between the switch/key input logic and the LED/seven-segment output logic, which read `result` and the flags directly.

---
 rtl/seq_alu_pkg.sv | 19 +
 rtl/shift_add_mul.sv | 63 ++++++
 rtl/seq_alu.sv | 131 +++++++++++++
 tb/tb_seq_alu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_LOGIC = 3'b001;
    localparam logic [2:0] OP_ACC   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_NZ    = 3'b100;
    localparam logic [2:0] OP_MIX   = 3'b101;
    localparam logic [2:0] OP_CLR   = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
// 'a' is the multiplicand (consumed LSB first), 'b' the multiplier that is
// shifted left each step. step_done flags the cycle whose edge performs the
// final iteration, so the owner can leave its MUL state on that same edge.
module shift_add_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 step_done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [2*WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;

    // Next-state: load operands, or run one shift-add step while the counter is live.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            cnt_d    = CW'(WIDTH);
            mcand_d  = a;
            mplier_d = {{WIDTH{1'b0}}, b};
            acc_d    = '0;
        end else if (cnt_q != '0) begin
            if (mcand_q[0]) begin
                acc_d = acc_q + mplier_q;
            end
            mplier_d = mplier_q << 1;
            mcand_d  = mcand_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    // Multiplier state registers, cleared asynchronously even mid-operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign step_done = (cnt_q == CW'(1));
    assign product   = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake, accumulate, multi-cycle multiply
// and status flags. All outputs come straight from registers.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero,
    output logic                 err
);

    localparam int W2 = 2 * WIDTH;

    state_t            state_q;
    logic [W2-1:0]     result_q;
    logic              carry_q, zero_q, err_q, done_q, busy_q;

    logic [W2-1:0]     alu_res_d;
    logic              alu_carry_d, alu_err_d;
    logic [WIDTH:0]    add_sum;
    logic [W2:0]       acc_sum;

    logic              mul_load;
    logic              mul_step_done;
    logic [W2-1:0]     mul_product;

    // Starts are only honoured in IDLE; everything else is ignored, not queued.
    assign mul_load = (state_q == IDLE) && start && (op == OP_MUL);

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .resetn    (resetn),
        .load      (mul_load),
        .a         (a),
        .b         (b),
        .step_done (mul_step_done),
        .product   (mul_product)
    );

    // Single-cycle datapath; ACC builds on the last completed result.
    always_comb begin
        add_sum     = {1'b0, a} + {1'b0, b};
        acc_sum     = {1'b0, result_q} + {{(WIDTH + 1){1'b0}}, a};
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        alu_err_d   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_d   = {{(WIDTH - 1){1'b0}}, add_sum};
                alu_carry_d = add_sum[WIDTH];
            end
            OP_LOGIC: alu_res_d = {~(a & b), a ~^ b};
            OP_ACC: begin
                alu_res_d   = acc_sum[W2-1:0];
                alu_carry_d = acc_sum[W2];
            end
            OP_NZ:   alu_res_d = {{WIDTH{1'b0}}, {WIDTH{|{a, b}}}};
            OP_MIX:  alu_res_d = {a, ~b};
            OP_CLR:  alu_res_d = '0;
            OP_RSVD: alu_err_d = 1'b1;
            default: alu_res_d = '0;
        endcase
    end

    // Control FSM plus result/flag registers; done is a one-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            state_q <= MUL;
                            busy_q  <= 1'b1;
                        end else begin
                            result_q <= alu_res_d;
                            carry_q  <= alu_carry_d;
                            zero_q   <= (alu_res_d == '0);
                            err_q    <= alu_err_d;
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_step_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    result_q <= mul_product;
                    carry_q  <= 1'b0;
                    zero_q   <= (mul_product == '0);
                    err_q    <= 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH = 4): directed scenarios followed by
// randomized operations, all compared against an arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W  = 4;
    localparam int W2 = 2 * W;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [2:0]      op;
    logic [W-1:0]    a, b;
    logic            busy, done, carry, zero, err;
    logic [W2-1:0]   result;

    int tests = 0;
    int fails = 0;

    // Reference model state: the last completed result and flags.
    logic [W2-1:0]   m_res;
    logic            m_carry, m_zero, m_err;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero),
        .err    (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the opcode rules.
    task automatic model(input logic [2:0] o, input int unsigned ia, input int unsigned ib);
        int unsigned s;
        int unsigned wm;
        wm = (1 << W) - 1;
        m_carry = 1'b0;
        m_err   = 1'b0;
        case (o)
            OP_ADD: begin
                s = ia + ib;
                m_res = W2'(s);
                m_carry = ((s >> W) & 1) != 0;
            end
            OP_LOGIC: m_res = W2'((((~(ia & ib)) & wm) << W) | ((~(ia ^ ib)) & wm));
            OP_ACC: begin
                s = int'(m_res) + ia;
                m_carry = ((s >> W2) & 1) != 0;
                m_res = W2'(s);
            end
            OP_MUL:  m_res = W2'(ia * ib);
            OP_NZ:   m_res = ((ia | ib) != 0) ? W2'(wm) : '0;
            OP_MIX:  m_res = W2'((ia << W) | ((~ib) & wm));
            OP_CLR:  m_res = '0;
            default: begin
                m_res = '0;
                m_err = 1'b1;
            end
        endcase
        m_zero = (m_res == '0);
    endtask

    task automatic check_outputs();
        chk("result", 32'(result), 32'(m_res));
        chk("carry",  32'(carry),  32'(m_carry));
        chk("zero",   32'(zero),   32'(m_zero));
        chk("err",    32'(err),    32'(m_err));
    endtask

    // Issue one operation at a negedge; optionally poke an extra start at
    // busy-cycle 'intrude_at' of a MUL, which must be ignored.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input int intrude_at, input logic [2:0] io,
                          input logic [W-1:0] ja, input logic [W-1:0] jb);
        start = 1'b1; op = o; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0;
        model(o, int'(ia), int'(ib));
        if (o != OP_MUL) begin
            chk("done_1cyc", 32'(done), 32'd1);
            chk("busy_1cyc", 32'(busy), 32'd0);
        end else begin
            int lat;
            int busy_cnt;
            lat = 1;
            busy_cnt = 0;
            while (done !== 1'b1 && lat < 20) begin
                if (busy === 1'b1) busy_cnt++;
                if (lat == intrude_at) begin
                    start = 1'b1; op = io; a = ja; b = jb;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
            start = 1'b0;
            chk("mul_latency", 32'(lat - 1), 32'(W + 1));
            chk("mul_busy_cycles", 32'(busy_cnt), 32'(W + 1));
            chk("mul_busy_at_done", 32'(busy), 32'd0);
        end
        check_outputs();
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("result_hold", 32'(result), 32'(m_res));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
        m_res = '0; m_carry = 1'b0; m_zero = 1'b0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry",  32'(carry),  32'd0);
        chk("rst_zero",   32'(zero),   32'd0);
        chk("rst_err",    32'(err),    32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // ADD with carry out of the operand width
        run_op(OP_ADD, 4'd9, 4'd8, 0, OP_ADD, 4'd0, 4'd0);
        chk("add_9_8", 32'(result), 32'h11);
        idle_check();

        // MUL 15x15 then three back-to-back ACCs started in the done cycle
        run_op(OP_MUL, 4'hF, 4'hF, 0, OP_ADD, 4'd0, 4'd0);
        chk("mul_15_15", 32'(result), 32'hE1);
        run_op(OP_ACC, 4'hF, 4'd0, 0, OP_ADD, 4'd0, 4'd0);
        chk("acc1", 32'(result), 32'hF0);
        run_op(OP_ACC, 4'hF, 4'd0, 0, OP_ADD, 4'd0, 4'd0);
        chk("acc2", 32'(result), 32'hFF);
        run_op(OP_ACC, 4'hF, 4'd0, 0, OP_ADD, 4'd0, 4'd0);
        chk("acc3_wrap", 32'(result), 32'h0E);
        chk("acc3_carry", 32'(carry), 32'd1);
        idle_check();

        run_op(OP_MUL, 4'd0, 4'd7, 0, OP_ADD, 4'd0, 4'd0);
        chk("mul_zero", 32'(zero), 32'd1);
        idle_check();

        // ADD poked while MUL is busy must be dropped
        run_op(OP_MUL, 4'd3, 4'd5, 2, OP_ADD, 4'd1, 4'd1);
        chk("mul_3_5", 32'(result), 32'h0F);
        idle_check();

        // Asynchronous reset after two MUL iterations
        start = 1'b1; op = OP_MUL; a = 4'd3; b = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_busy",   32'(busy),   32'd0);
        chk("midrst_done",   32'(done),   32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_zero",   32'(zero),   32'd0);
        chk("midrst_carry",  32'(carry),  32'd0);
        chk("midrst_err",    32'(err),    32'd0);
        @(negedge clk);
        resetn = 1'b1;
        m_res = '0; m_carry = 1'b0; m_zero = 1'b0; m_err = 1'b0;
        idle_check();
        run_op(OP_ADD, 4'd2, 4'd3, 0, OP_ADD, 4'd0, 4'd0);
        chk("add_after_rst", 32'(result), 32'h05);
        idle_check();

        // Reserved opcode, then LOGIC clears err, then NZ of zeros
        run_op(OP_RSVD, 4'd5, 4'd6, 0, OP_ADD, 4'd0, 4'd0);
        chk("rsvd_err", 32'(err), 32'd1);
        run_op(OP_LOGIC, 4'hA, 4'hC, 0, OP_ADD, 4'd0, 4'd0);
        chk("logic_err_clr", 32'(err), 32'd0);
        run_op(OP_NZ, 4'd0, 4'd0, 0, OP_ADD, 4'd0, 4'd0);
        chk("nz_zero", 32'(zero), 32'd1);
        idle_check();

        // Randomized operations with occasional gaps and busy-time intrusions
        for (int i = 0; i < 200; i++) begin
            logic [2:0]   ro, io;
            logic [W-1:0] ra, rb, ja, jb;
            int           at;
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            io = 3'($urandom_range(0, 7));
            ja = W'($urandom);
            jb = W'($urandom);
            at = (ro == OP_MUL && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, W + 1)) : 0;
            run_op(ro, ra, rb, at, io, ja, jb);
            if ($urandom_range(0, 3) == 0) idle_check();
        end
        idle_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
